// File: rtl/fifo_rd_sched_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_sched_pkg
// Shared definitions for the FIFO read scheduler:
//   - scheduler state encoding
//   - datapath widths (data, beat, channel mask, length)
//   - bit positions of the fields inside a 140-bit FIFO word
//   - binary-to-gray helper used on the 128-bit payload
// -----------------------------------------------------------------------------
package fifo_rd_sched_pkg;

  localparam int DATA_W    = 128;
  localparam int BEAT_W    = 16;
  localparam int CH_W      = 8;
  localparam int LEN_W     = 4;
  localparam int MAX_BEATS = 8;
  localparam int CNT_W     = 16;

  localparam int WORD_W    = DATA_W + CH_W + LEN_W;

  // FIFO word layout: {data, channel mask, length}
  localparam int LEN_LSB   = 0;
  localparam int LEN_MSB   = LEN_LSB + LEN_W - 1;
  localparam int CH_LSB    = LEN_MSB + 1;
  localparam int CH_MSB    = CH_LSB + CH_W - 1;
  localparam int DATA_LSB  = CH_MSB + 1;
  localparam int DATA_MSB  = DATA_LSB + DATA_W - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  function automatic logic [DATA_W-1:0] bin2gray(input logic [DATA_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/fifo_data_resolu.sv
// -----------------------------------------------------------------------------
// fifo_data_resolu
// Splits one FIFO word into its fields and gray-codes the payload.
// Purely combinational.
//
// Ports
//   i_word      in   WORD_W  raw FIFO word {data, mask, len}
//   o_gray      out  DATA_W  gray-coded payload (data ^ data>>1)
//   o_ch        out  CH_W    channel mask
//   o_len       out  LEN_W   length in beats
//   o_len_ok    out  1       length is in 1..MAX_BEATS
//   o_len_over  out  1       length is above MAX_BEATS
//   o_ch_zero   out  1       channel mask is all zeros
// -----------------------------------------------------------------------------
module fifo_data_resolu
  import fifo_rd_sched_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  output logic [DATA_W-1:0] o_gray,
  output logic [CH_W-1:0]   o_ch,
  output logic [LEN_W-1:0]  o_len,
  output logic              o_len_ok,
  output logic              o_len_over,
  output logic              o_ch_zero
);

  logic [DATA_W-1:0] w_data;

  assign w_data     = i_word[DATA_MSB:DATA_LSB];
  assign o_ch       = i_word[CH_MSB:CH_LSB];
  assign o_len      = i_word[LEN_MSB:LEN_LSB];

  assign o_gray     = bin2gray(w_data);

  assign o_len_over = (o_len > LEN_W'(MAX_BEATS));
  assign o_len_ok   = (o_len != '0) && !o_len_over;
  assign o_ch_zero  = (o_ch == '0);

endmodule

// File: rtl/fifo_rd_sched.sv
// -----------------------------------------------------------------------------
// fifo_rd_sched
// Pops packet words from a source FIFO (one-cycle read latency), gray-codes
// the 128-bit payload and streams it out MSB-first as 16-bit beats with a
// valid/ready handshake. Malformed words are dropped and flagged.
//
// Ports
//   clk         in   1    rising-edge clock
//   rst_n       in   1    asynchronous active-low reset
//   fifo_empty  in   1    source FIFO empty
//   fifo_rd_en  out  1    FIFO read strobe, data arrives next cycle
//   fifo_dout   in   140  {data[127:0], mask[7:0], len[3:0]}
//   dout        out  16   output beat (gray-coded)
//   dout_vld    out  1    beat valid
//   dout_rdy    in   1    downstream ready
//   dout_ch     out  8    channel mask of the current packet
//   dout_last   out  1    final beat of the packet
//   busy        out  1    scheduler not in IDLE
//   err_len     out  1    sticky: a length above 8 was seen
//   err_ch      out  1    sticky: a zero mask with a legal length was seen
//   err_clr     in   1    clears both sticky flags (a new error wins)
//   pkt_cnt     out  16   completed packets, wraps
// -----------------------------------------------------------------------------
module fifo_rd_sched
  import fifo_rd_sched_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         fifo_empty,
  output logic         fifo_rd_en,
  input  logic [139:0] fifo_dout,
  output logic [15:0]  dout,
  output logic         dout_vld,
  input  logic         dout_rdy,
  output logic [7:0]   dout_ch,
  output logic         dout_last,
  output logic         busy,
  output logic         err_len,
  output logic         err_ch,
  input  logic         err_clr,
  output logic [15:0]  pkt_cnt
);

  state_t             r_state;
  state_t             w_next;

  logic [DATA_W-1:0]  r_shift;
  logic [CH_W-1:0]    r_ch;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_beat;
  logic [CNT_W-1:0]   r_pkt_cnt;
  logic               r_err_len;
  logic               r_err_ch;

  logic [DATA_W-1:0]  w_gray;
  logic [CH_W-1:0]    w_ch;
  logic [LEN_W-1:0]   w_len;
  logic               w_len_ok;
  logic               w_len_over;
  logic               w_ch_zero;

  logic               w_accept;
  logic               w_last;
  logic               w_pkt_done;
  logic               w_set_len;
  logic               w_set_ch;

  // ---------------------------------------------------------------------------
  // Field extraction / gray conversion of the word returned by the FIFO.
  // The fields are only meaningful in LOAD, one cycle after the read strobe.
  // ---------------------------------------------------------------------------
  fifo_data_resolu u_resolu (
    .i_word     (fifo_dout),
    .o_gray     (w_gray),
    .o_ch       (w_ch),
    .o_len      (w_len),
    .o_len_ok   (w_len_ok),
    .o_len_over (w_len_over),
    .o_ch_zero  (w_ch_zero)
  );

  assign w_accept   = dout_vld && dout_rdy;
  // r_beat counts beats already accepted, so the beat on the bus is r_beat+1
  assign w_last     = ((r_beat + LEN_W'(1)) == r_len);
  assign w_pkt_done = (r_state == ST_SEND) && w_accept && w_last;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          w_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // Words with a length outside 1..8 or an empty mask produce no beats
        if (w_len_ok && !w_ch_zero) begin
          w_next = ST_SEND;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (w_accept && w_last) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    fifo_rd_en = 1'b0;
    dout       = '0;
    dout_vld   = 1'b0;
    dout_ch    = '0;
    dout_last  = 1'b0;
    busy       = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        // Gated with rst_n so no read can be issued while reset is held
        fifo_rd_en = !fifo_empty && rst_n;
      end
      ST_SEND: begin
        dout      = r_shift[DATA_W-1 -: BEAT_W];
        dout_vld  = 1'b1;
        dout_ch   = r_ch;
        dout_last = w_last;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Packet datapath: capture in LOAD, shift out on each accepted beat.
  // Everything holds while the downstream stalls.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_ch    <= '0;
      r_len   <= '0;
      r_beat  <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_shift <= w_gray;
          r_ch    <= w_ch;
          r_len   <= w_len;
          r_beat  <= '0;
        end
        ST_SEND: begin
          if (w_accept) begin
            r_shift <= r_shift << BEAT_W;
            r_beat  <= r_beat + LEN_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags and packet counter
  // ---------------------------------------------------------------------------
  assign w_set_len = (r_state == ST_LOAD) && w_len_over;
  assign w_set_ch  = (r_state == ST_LOAD) && w_len_ok && w_ch_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_len <= 1'b0;
      r_err_ch  <= 1'b0;
    end else begin
      // A new error in the same cycle as err_clr keeps the flag set
      r_err_len <= w_set_len || (r_err_len && !err_clr);
      r_err_ch  <= w_set_ch  || (r_err_ch  && !err_clr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_cnt <= '0;
    end else if (w_pkt_done) begin
      r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
    end
  end

  assign err_len = r_err_len;
  assign err_ch  = r_err_ch;
  assign pkt_cnt = r_pkt_cnt;

endmodule

// File: tb/tb_fifo_rd_sched.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_sched
// Directed bench for fifo_rd_sched: a small FIFO responder with one-cycle
// read latency, a beat monitor and hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_fifo_rd_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fifo_empty;
  logic         fifo_rd_en;
  logic [139:0] fifo_dout = '0;
  logic [15:0]  dout;
  logic         dout_vld;
  logic         dout_rdy;
  logic [7:0]   dout_ch;
  logic         dout_last;
  logic         busy;
  logic         err_len;
  logic         err_ch;
  logic         err_clr;
  logic [15:0]  pkt_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fifo_rd_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .dout       (dout),
    .dout_vld   (dout_vld),
    .dout_rdy   (dout_rdy),
    .dout_ch    (dout_ch),
    .dout_last  (dout_last),
    .busy       (busy),
    .err_len    (err_len),
    .err_ch     (err_ch),
    .err_clr    (err_clr),
    .pkt_cnt    (pkt_cnt)
  );

  // Source FIFO model: word appears on fifo_dout the cycle after the strobe
  logic [139:0] mem [0:63];
  int wp = 0;
  int rp = 0;
  assign fifo_empty = (rp == wp);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_dout <= mem[rp[5:0]];
      rp        <= rp + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Beat monitor, sampled mid-cycle
  logic [15:0] bq [$];
  logic        lq [$];
  logic [7:0]  cq [$];
  int          cycq [$];
  int          rd_in_send = 0;
  int          rd_on_empty = 0;
  int          last_rd_cyc = 0;

  always @(negedge clk) begin
    if (dout_vld && dout_rdy) begin
      bq.push_back(dout);
      lq.push_back(dout_last);
      cq.push_back(dout_ch);
      cycq.push_back(cyc);
    end
    if (fifo_rd_en) last_rd_cyc = cyc;
    if (fifo_rd_en && dout_vld) rd_in_send = rd_in_send + 1;
    if (fifo_rd_en && fifo_empty) rd_on_empty = rd_on_empty + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [139:0] mk_word(input logic [127:0] d, input logic [7:0] m,
                                           input logic [3:0] l);
    return {d, m, l};
  endfunction

  function automatic logic [15:0] exp_beat(input logic [127:0] d, input int k);
    logic [127:0] g;
    g = d ^ (d >> 1);
    return g[127 - 16*k -: 16];
  endfunction

  task automatic push(input logic [139:0] w);
    mem[wp[5:0]] = w;
    wp = wp + 1;
  endtask

  task automatic clear_mon();
    bq.delete();
    lq.delete();
    cq.delete();
    cycq.delete();
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (fifo_empty && !busy) begin
        done = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
    check("idle_reached", 32'(done), 32'd1);
  endtask

  task automatic wait_vld();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dout_vld) begin
        seen = 1'b1;
        break;
      end
    end
    check("vld_seen", 32'(seen), 32'd1);
  endtask

  logic [127:0] d_top;
  logic [127:0] d_a;
  logic [127:0] d_b;
  logic [127:0] d_rst;
  int           rd_send_before;

  initial begin
    d_top = 128'hFFFF << 112;
    d_a   = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
    d_b   = {64'hA5A5_0F0F_1234_8001, 64'h7FFF_0000_C3C3_5A5A};
    d_rst = 128'h1234 << 112;

    dout_rdy = 1'b1;
    err_clr  = 1'b0;
    rst_n    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_vld",    32'(dout_vld),  32'd0);
    check("rst_dout",   32'(dout),      32'd0);
    check("rst_busy",   32'(busy),      32'd0);
    check("rst_pkt",    32'(pkt_cnt),   32'd0);
    check("rst_errs",   32'({err_len, err_ch}), 32'd0);

    // Scenario 1: len=2, mask=0x04; word is queued while reset is held
    push(mk_word(d_top, 8'h04, 4'd2));
    #1;
    check("rst_no_read", 32'(fifo_rd_en), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_idle();
    check("s1_nbeats",  32'(bq.size()), 32'd2);
    check("s1_beat1",   32'(bq.size() > 0 ? bq[0] : 16'h0), 32'h8000);
    check("s1_beat2",   32'(bq.size() > 1 ? bq[1] : 16'h0), 32'h8000);
    check("s1_last1",   32'(lq.size() > 0 ? lq[0] : 1'b1), 32'd0);
    check("s1_last2",   32'(lq.size() > 1 ? lq[1] : 1'b0), 32'd1);
    check("s1_ch",      32'(cq.size() > 0 ? cq[0] : 8'h0), 32'h04);
    check("s1_latency", 32'(cycq.size() > 0 ? cycq[0] - last_rd_cyc : 0), 32'd2);
    check("s1_pkt",     32'(pkt_cnt), 32'd1);
    clear_mon();

    // Scenario 2: stall the first beat for 3 cycles
    dout_rdy = 1'b0;
    push(mk_word(d_top, 8'h04, 4'd2));
    wait_vld();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check("s2_hold_dout", 32'(dout),      32'h8000);
      check("s2_hold_last", 32'(dout_last), 32'd0);
      check("s2_hold_ch",   32'(dout_ch),   32'h04);
    end
    @(posedge clk);
    #1 dout_rdy = 1'b1;
    wait_idle();
    check("s2_nbeats", 32'(bq.size()), 32'd2);
    check("s2_beat2",  32'(bq.size() > 1 ? bq[1] : 16'h0), 32'h8000);
    check("s2_pkt",    32'(pkt_cnt), 32'd2);
    clear_mon();

    // Scenario 3: dropped words
    push(mk_word(d_top, 8'h04, 4'd0));
    wait_idle();
    check("s3_len0_flags", 32'({err_len, err_ch}), 32'd0);
    push(mk_word(d_top, 8'h04, 4'd12));
    wait_idle();
    check("s3_len12_errlen", 32'(err_len), 32'd1);
    check("s3_len12_errch",  32'(err_ch),  32'd0);
    push(mk_word(d_top, 8'h00, 4'd3));
    wait_idle();
    check("s3_mask0_errch", 32'(err_ch), 32'd1);
    check("s3_nbeats",      32'(bq.size()), 32'd0);
    check("s3_pkt",         32'(pkt_cnt), 32'd2);

    // Scenario 4: err_clr coincides with the LOAD of a new len=12 word
    push(mk_word(d_top, 8'h04, 4'd12));
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    check("s4_set_wins", 32'(err_len), 32'd1);
    check("s4_ch_clr",   32'(err_ch),  32'd0);
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    check("s4_lone_clr", 32'(err_len), 32'd0);
    wait_idle();
    clear_mon();

    // Scenario 5: two back-to-back len=8 packets
    rd_send_before = rd_in_send;
    push(mk_word(d_a, 8'hA5, 4'd8));
    push(mk_word(d_b, 8'h3C, 4'd8));
    wait_idle();
    check("s5_nbeats", 32'(bq.size()), 32'd16);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("s5_beat%0d", k),
            32'(bq.size() > k ? bq[k] : 16'h0),
            32'(k < 8 ? exp_beat(d_a, k) : exp_beat(d_b, k - 8)));
    end
    check("s5_last_a",  32'(lq.size() > 7  ? lq[7]  : 1'b0), 32'd1);
    check("s5_nlast_a", 32'(lq.size() > 6  ? lq[6]  : 1'b1), 32'd0);
    check("s5_last_b",  32'(lq.size() > 15 ? lq[15] : 1'b0), 32'd1);
    check("s5_ch_a",    32'(cq.size() > 0  ? cq[0]  : 8'h0), 32'hA5);
    check("s5_ch_b",    32'(cq.size() > 8  ? cq[8]  : 8'h0), 32'h3C);
    check("s5_gap",     32'(cycq.size() > 8 ? cycq[8] - cycq[7] : 0), 32'd3);
    check("s5_rd_in_send", 32'(rd_in_send - rd_send_before), 32'd0);
    check("s5_pkt",     32'(pkt_cnt), 32'd4);
    clear_mon();

    // Scenario 6: reset while beat 3 of a len=8 packet is on the bus
    push(mk_word(d_a, 8'hA5, 4'd8));
    wait_vld();
    @(negedge clk);
    @(negedge clk);
    check("s6_beat3", 32'(dout), 32'(exp_beat(d_a, 2)));
    #1 rst_n = 1'b0;
    #1;
    check("s6_rst_vld",  32'(dout_vld),  32'd0);
    check("s6_rst_dout", 32'(dout),      32'd0);
    check("s6_rst_ch",   32'(dout_ch),   32'd0);
    check("s6_rst_last", 32'(dout_last), 32'd0);
    check("s6_rst_busy", 32'(busy),      32'd0);
    check("s6_rst_pkt",  32'(pkt_cnt),   32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    clear_mon();
    check("s6_no_reread", 32'(busy), 32'd0);
    push(mk_word(d_rst, 8'h81, 4'd1));
    wait_idle();
    check("s6_nbeats", 32'(bq.size()), 32'd1);
    check("s6_beat",   32'(bq.size() > 0 ? bq[0] : 16'h0), 32'h1B2E);
    check("s6_last",   32'(lq.size() > 0 ? lq[0] : 1'b0), 32'd1);
    check("s6_ch",     32'(cq.size() > 0 ? cq[0] : 8'h0), 32'h81);
    check("s6_pkt",    32'(pkt_cnt), 32'd1);

    check("rd_on_empty", 32'(rd_on_empty), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the bench always terminates
  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "time limit");
  end

endmodule
